// File: rtl/oqpsk_demod.sv
// oqpsk_demod: integrate-and-dump OQPSK slicer with Q offset by half a symbol, feeding a 4-entry bit FIFO
module oqpsk_demod #(
   parameter int SPS = 16,
   parameter int DW  = 13
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 smp_valid,
   input  logic signed [DW-1:0] i_smp,
   input  logic signed [DW-1:0] q_smp,
   input  logic                 sync,
   output logic                 bit_data,
   output logic                 bit_valid,
   input  logic                 bit_ready,
   output logic                 locked,
   output logic                 overflow
);
   localparam int CW = $clog2(SPS);
   localparam int AW = DW + CW;
   localparam logic [CW-1:0] LAST = CW'(SPS - 1);
   localparam logic [CW-1:0] HALF = CW'(SPS / 2 - 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic signed [AW-1:0] acc_i, acc_q, sum_i, sum_q;
   logic q_skip, load, take, i_dump, q_dump, push, push_bit, pop, full, wr;
   logic [3:0] mem;
   logic [1:0] rd, wa;
   logic [2:0] fill;
   // a sync that starts a symbol loads fresh windows; sync at cnt=0 in RUN is an ordinary sample
   always_comb begin
      load = smp_valid & sync & (state == IDLE | cnt != '0);
      take = smp_valid & (state == RUN) & !load;
      sum_i = acc_i + AW'(i_smp);
      sum_q = acc_q + AW'(q_smp);
      i_dump = take & (cnt == LAST);
      q_dump = take & (cnt == HALF);
      push = i_dump | (q_dump & !q_skip);
      push_bit = i_dump ? !sum_i[AW-1] : !sum_q[AW-1];
      pop = bit_valid & bit_ready;
      full = fill[2];
      wr = push & (!full | pop);
      wa = rd + fill[1:0];
   end
   assign bit_data = mem[rd];
   assign bit_valid = fill != '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         locked <= 1'b0;
         cnt <= '0;
         acc_i <= '0;
         acc_q <= '0;
         q_skip <= 1'b1;
      end else if (load) begin
         state <= RUN;
         locked <= 1'b1;
         cnt <= CW'(1);
         acc_i <= AW'(i_smp);
         acc_q <= AW'(q_smp);
         q_skip <= 1'b1;
      end else if (take) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
         acc_i <= i_dump ? '0 : sum_i;
         acc_q <= q_dump ? '0 : sum_q;
         q_skip <= q_skip & !q_dump;
      end
   end
   // when full with a pop, the write slot equals the head being popped
   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '0;
         rd <= '0;
         fill <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) mem[wa] <= push_bit;
         if (pop) rd <= rd + 2'd1;
         fill <= fill + {2'b0, wr} - {2'b0, pop};
         if (push & full & !pop) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_oqpsk_demod.sv
// tb_oqpsk_demod: directed vectors for oqpsk_demod with hand-computed bit sequences
module tb_oqpsk_demod;
   logic clk = 1'b0, rst = 1'b0, smp_valid = 1'b0, sync = 1'b0, bit_ready = 1'b0;
   logic signed [12:0] i_smp = '0, q_smp = '0;
   logic bit_data, bit_valid, locked, overflow;
   int n_checks = 0, n_errors = 0, got_n = 0, base;
   logic [31:0] got_v = '0;
   oqpsk_demod #(.SPS(16), .DW(13)) dut (
      .clk(clk), .rst(rst), .smp_valid(smp_valid), .i_smp(i_smp), .q_smp(q_smp),
      .sync(sync), .bit_data(bit_data), .bit_valid(bit_valid), .bit_ready(bit_ready),
      .locked(locked), .overflow(overflow)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (!rst && bit_valid && bit_ready) begin
      got_v = {got_v[30:0], bit_data};
      got_n = got_n + 1;
   end
   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic idle(input int n);
      smp_valid = 1'b0;
      sync = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask
   task automatic smp(input int i, input int q, input bit s);
      smp_valid = 1'b1;
      i_smp = 13'(i);
      q_smp = 13'(q);
      sync = s;
      @(posedge clk); #1;
      smp_valid = 1'b0;
      sync = 1'b0;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
   endtask
   function automatic int ipat(input int k);
      return ((k / 16) % 2 == 0) ? 1000 : -1000;
   endfunction
   task automatic play(input int k0, input int n, input bit gap);
      for (int k = k0; k < k0 + n; k++) begin
         smp(ipat(k), k < 24 ? 500 : -500, k == 0);
         if (gap) idle(1);
      end
   endtask
   task automatic expect_bits(input string tag, input int n, input int exp);
      check({tag, "_count"}, got_n - base, n);
      check({tag, "_bits"}, int'(got_v & ((32'd1 << n) - 1)), exp);
   endtask
   initial begin
      do_reset();
      check("rst_bit_data", bit_data, 0);
      check("rst_bit_valid", bit_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_overflow", overflow, 0);
      // basic decode: I +,-  Q all negative
      bit_ready = 1'b1;
      base = got_n;
      for (int k = 0; k < 40; k++) begin
         smp(ipat(k), -500, k == 0);
         if (k == 0) check("basic_locked", locked, 1);
         if (k == 7) check("basic_q_partial_dropped", bit_valid, 0);
         if (k == 14) check("basic_pre_i0", bit_valid, 0);
         if (k == 15) begin
            check("basic_i0_valid", bit_valid, 1);
            check("basic_i0_data", bit_data, 1);
         end
      end
      idle(3);
      expect_bits("basic", 4, 'b1000);
      // zero sum decides 1, full-scale negative does not wrap
      do_reset();
      base = got_n;
      for (int k = 0; k < 32; k++)
         smp(k < 16 ? ((k % 2 == 0) ? 4095 : -4095) : -4096, 0, k == 0);
      idle(3);
      expect_bits("boundary", 3, 'b110);
      // backpressure and overflow
      do_reset();
      bit_ready = 1'b0;
      base = got_n;
      play(0, 16, 1'b0);
      check("bp_valid_first", bit_valid, 1);
      play(16, 31, 1'b0);
      check("bp_no_ovf_yet", overflow, 0);
      play(47, 1, 1'b0);
      check("bp_ovf", overflow, 1);
      check("bp_head_held", bit_data, 1);
      bit_ready = 1'b1;
      idle(6);
      expect_bits("bp_drain", 4, 'b1100);
      check("bp_empty", bit_valid, 0);
      check("bp_ovf_sticky", overflow, 1);
      // full FIFO with simultaneous pop
      do_reset();
      bit_ready = 1'b0;
      base = got_n;
      play(0, 47, 1'b0);
      bit_ready = 1'b1;
      play(47, 1, 1'b0);
      idle(6);
      check("full_pop_no_ovf", overflow, 0);
      expect_bits("full_pop", 5, 'b11001);
      // resync at cnt=5 of the second symbol
      do_reset();
      base = got_n;
      for (int k = 0; k < 21; k++) smp(-1000, -500, k == 0);
      for (int k = 0; k < 24; k++) begin
         smp(1000, 500, k == 0);
         if (k == 7) check("resync_q_partial_dropped", bit_valid, 0);
         if (k == 14) check("resync_no_early_i", bit_valid, 0);
         if (k == 15) check("resync_i_at_15", bit_valid, 1);
      end
      idle(3);
      expect_bits("resync", 3, 'b011);
      // gapped input gives the same sequence as the gap-free run
      do_reset();
      base = got_n;
      play(0, 48, 1'b1);
      idle(4);
      expect_bits("gapped", 5, 'b11001);
      // reset mid-symbol
      do_reset();
      bit_ready = 1'b0;
      play(0, 20, 1'b0);
      check("pre_rst_valid", bit_valid, 1);
      do_reset();
      check("mid_rst_bit_data", bit_data, 0);
      check("mid_rst_bit_valid", bit_valid, 0);
      check("mid_rst_locked", locked, 0);
      check("mid_rst_overflow", overflow, 0);
      play(1, 20, 1'b0);
      check("idle_ignores_locked", locked, 0);
      check("idle_ignores_valid", bit_valid, 0);
      smp(1000, 500, 1'b1);
      check("relock", locked, 1);
      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/oqpsk_demod.md
# oqpsk_demod

Receive-side counterpart of the OQPSK raised-cosine modulators: takes 13-bit signed I/Q baseband samples (Q offset by half a symbol) and recovers the serial bit stream. It integrates and dumps I over aligned symbol windows and Q over half-symbol-offset windows, then sign-slices. Decided bits are buffered in a 4-entry FIFO with a valid/ready output. Sits beside the modulators in the user project wrapper, driven by wb_clk_i.

## Interface
- SPS, 16: samples per symbol; even, ≥ 4.
- DW, 13: sample width, two's complement.
- clk  in  1  system clock (wb_clk_i at wrapper).
- rst  in  1  synchronous, active-high reset.
- smp_valid  in  1  i_smp/q_smp carry a sample this cycle.
- i_smp  in  DW  signed in-phase sample.
- q_smp  in  DW  signed quadrature sample.
- sync  in  1  qualified by smp_valid; marks the first sample of an I symbol.
- bit_data  out  1  recovered bit at FIFO head.
- bit_valid  out  1  FIFO non-empty.
- bit_ready  in  1  consumer accepts bit_data when bit_valid & bit_ready.
- locked  out  1  high in RUN state.
- overflow  out  1  sticky: a bit was dropped because the FIFO was full.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: samples ignored. smp_valid & sync → RUN; that sample is symbol position cnt=0 and is accumulated.
- cnt: clog2(SPS) bits, advances only on accepted samples, wraps SPS-1 → 0.
- Accumulators accI, accQ: signed, DW+clog2(SPS) bits (no saturation possible).
- I window: cnt 0..SPS-1. On sample with cnt=SPS-1: I bit = (accI+i_smp ≥ 0), push; accI cleared.
- Q window: cnt SPS/2..SPS/2-1 (next symbol). On sample with cnt=SPS/2-1: Q bit = (accQ+q_smp ≥ 0), push; accQ cleared.
- First Q dump after entering RUN (or after resync) is a partial window: discarded, not pushed.
- Bit mapping: sum ≥ 0 → 1, < 0 → 0 (zero decides 1).
- Output order: I0, Q0, I1, Q1, …
- sync during RUN: at cnt=0 it is a no-op; at any other cnt it is a resync: that sample becomes cnt=0, both accumulators restart with that sample, the Q partial-window discard rearms, no bit from the interrupted windows is pushed.
- FIFO: 4 entries. Push and pop in the same cycle always succeed, including when full (pop first). Push when full without pop: bit dropped, overflow set; cleared only by rst.
- rst at any time: state IDLE, cnt=0, accumulators 0, FIFO emptied, overflow 0.

## Timing
- Reset values: bit_data 0, bit_valid 0, locked 0, overflow 0.
- locked rises the cycle after the sync sample is accepted.
- Decision latency: bit_valid (if FIFO was empty) and bit_data valid the cycle after the dumping sample is accepted.
- overflow rises the cycle after the dropping push.
- Throughput: one sample per cycle; at most one push per accepted sample (I and Q dumps never coincide since SPS/2-1 ≠ SPS-1).
- bit_data/bit_valid hold stable while bit_valid & !bit_ready.

## Test plan
- Basic decode, SPS=16: sync on sample 0, i_smp=+1000 for 16 samples then -1000 for 16, q_smp=-500 throughout, bit_ready=1 → pushes after samples 15, 23, 31, 39 give 1, 0, 0, 0; nothing pushed after sample 7.
- Zero/boundary: i_smp alternating +4095/-4095 (sum 0) → I bit 1; full-scale -4096 ×16 (sum -65536) → I bit 0, no wrap.
- Backpressure/overflow: bit_ready=0, 5 bits produced → bit_valid=1 after first, FIFO holds first 4, overflow=1 one cycle after 5th push; then bit_ready=1 drains the 4 original bits in order.
- Full with simultaneous pop: FIFO full, bit_ready=1 on the cycle a new bit is pushed → no overflow, order preserved.
- Resync: sync at cnt=5 mid-RUN → no bit from interrupted windows, next I bit after sample 15 counted from resync, next Q dump at new cnt=7 discarded.
- Gapped input and reset: smp_valid toggling 1/0 → identical bit sequence to the gap-free run; rst asserted mid-symbol → all outputs 0 next cycle, IDLE until next sync.
